// File: rtl/binarization_input_ctrl.sv
// Window sequencer for the input-binarization datapath: gathers KERNEL_SIZE
// pixels, hands the window to the datapath and registers the thermometer result.
module binarization_input_ctrl #(
    parameter int KERNEL_SIZE = 9,
    parameter int BIT_WIDTH   = 8,
    parameter int CHANNEL_CNT = 256,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               abort,
    input  logic [CNT_WIDTH-1:0]               num_windows,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [BIT_WIDTH-1:0]               in_pixel,
    output logic [KERNEL_SIZE*BIT_WIDTH-1:0]   bin_pixel_in,
    input  logic [KERNEL_SIZE*CHANNEL_CNT-1:0] bin_pixel_out,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [KERNEL_SIZE*CHANNEL_CNT-1:0] out_data,
    output logic                               busy,
    output logic                               done,
    output logic [CNT_WIDTH-1:0]               win_cnt
);

    localparam int IW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(KERNEL_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    state_e                             state_q, state_d;
    logic [CNT_WIDTH-1:0]               nwin_q, nwin_d;
    logic [CNT_WIDTH-1:0]               issued_q, issued_d;
    logic [CNT_WIDTH-1:0]               win_q, win_d;
    logic [IW-1:0]                      g_idx_q, g_idx_d;
    logic [KERNEL_SIZE*BIT_WIDTH-1:0]   gbuf_q, gbuf_d;
    logic                               full_q, full_d;
    logic                               ov_q, ov_d;
    logic [KERNEL_SIZE*CHANNEL_CNT-1:0] od_q, od_d;
    logic                               done_q, done_d;

    logic                               accept;
    logic                               xfer;
    logic                               hs;
    logic [CNT_WIDTH-1:0]               issued_nx;

    assign accept    = (state_q == RUN) && !full_q && in_valid;
    assign xfer      = full_q && (!ov_q || out_ready);
    assign hs        = ov_q && out_ready;
    assign issued_nx = issued_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            nwin_q   <= '0;
            issued_q <= '0;
            win_q    <= '0;
            g_idx_q  <= '0;
            gbuf_q   <= '0;
            full_q   <= 1'b0;
            ov_q     <= 1'b0;
            od_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            nwin_q   <= nwin_d;
            issued_q <= issued_d;
            win_q    <= win_d;
            g_idx_q  <= g_idx_d;
            gbuf_q   <= gbuf_d;
            full_q   <= full_d;
            ov_q     <= ov_d;
            od_q     <= od_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        nwin_d   = nwin_q;
        issued_d = issued_q;
        win_d    = win_q;
        g_idx_d  = g_idx_q;
        gbuf_d   = gbuf_q;
        full_d   = full_q;
        ov_d     = ov_q;
        od_d     = od_q;
        done_d   = 1'b0;

        // A transfer on the handshake edge refills the stage, so it wins.
        if (hs) begin
            win_d = win_q + 1'b1;
            ov_d  = 1'b0;
        end
        if (xfer) begin
            od_d   = bin_pixel_out;
            ov_d   = 1'b1;
            full_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    nwin_d   = num_windows;
                    win_d    = '0;
                    g_idx_d  = '0;
                    issued_d = '0;
                    if (num_windows == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    gbuf_d[g_idx_q*BIT_WIDTH +: BIT_WIDTH] = in_pixel;
                    if (g_idx_q == LAST_IDX) begin
                        g_idx_d  = '0;
                        full_d   = 1'b1;
                        issued_d = issued_nx;
                        if (issued_nx == nwin_q) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        g_idx_d = g_idx_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (win_q == nwin_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d  = IDLE;
            ov_d     = 1'b0;
            full_d   = 1'b0;
            g_idx_d  = '0;
            issued_d = '0;
            win_d    = win_q;
            done_d   = 1'b0;
        end
    end

    assign in_ready     = (state_q == RUN) && !full_q;
    assign bin_pixel_in = gbuf_q;
    assign out_valid    = ov_q;
    assign out_data     = od_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign win_cnt      = win_q;

endmodule

// File: tb/tb_binarization_input_ctrl.sv
// Bench for binarization_input_ctrl with a behavioural thermometer datapath
// and a window scoreboard built from the pixels actually handed over.
module tb_binarization_input_ctrl;

    localparam int K  = 9;
    localparam int BW = 8;
    localparam int CH = 256;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [CW-1:0]   num_windows = '0;
    logic [BW-1:0]   in_pixel = '0;
    logic            in_ready;
    logic            out_valid;
    logic            busy;
    logic            done;
    logic [K*BW-1:0] bin_pixel_in;
    logic [K*CH-1:0] bin_pixel_out;
    logic [K*CH-1:0] out_data;
    logic [CW-1:0]   win_cnt;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int dc;
    int nw;
    bit fin;
    bit saw;
    logic [K*CH-1:0] got_q[$];
    logic [BW-1:0]   sent_q[$];
    logic [BW-1:0]   pix[K] = '{8'h00, 8'h7F, 8'h80, 8'h01, 8'hFF,
                                8'h00, 8'h00, 8'h00, 8'h00};

    always #5 clk = ~clk;

    binarization_input_ctrl #(
        .KERNEL_SIZE(K),
        .BIT_WIDTH(BW),
        .CHANNEL_CNT(CH),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .num_windows(num_windows),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_pixel(in_pixel),
        .bin_pixel_in(bin_pixel_in),
        .bin_pixel_out(bin_pixel_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .busy(busy),
        .done(done),
        .win_cnt(win_cnt)
    );

    // Signed pixel p lights the low p+128 channels.
    function automatic logic [CH-1:0] therm(input logic [BW-1:0] p);
        int n;
        logic [CH-1:0] t;
        n = int'($signed(p)) + 128;
        t = '0;
        for (int j = 0; j < CH; j++) if (j < n) t[j] = 1'b1;
        return t;
    endfunction

    always_comb begin
        bin_pixel_out = '0;
        for (int k = 0; k < K; k++)
            bin_pixel_out[k*CH +: CH] = therm(bin_pixel_in[k*BW +: BW]);
    end

    always @(negedge clk) begin
        if (out_valid && out_ready) got_q.push_back(out_data);
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        num_windows = CW'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_px(input logic [BW-1:0] p);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_pixel = p;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 200);
        chk("px_acc", 256'(in_ready), 256'(1'b1));
        if (in_ready) sent_q.push_back(p);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!done && t < budget);
        chk("done_seen", 256'(done), 256'(1'b1));
        @(posedge clk);
        #1;
    endtask

    task automatic check_wins(input string tag, input int n);
        logic [K*CH-1:0] w;
        chk({tag, "_cnt"}, 256'(got_q.size()), 256'(n));
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            w = got_q[i];
            for (int k = 0; k < K; k++)
                chk(tag, w[k*CH +: CH], therm(sent_q[i*K+k]));
        end
        got_q.delete();
        sent_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // reset values
        #23;
        chk("rst_inrdy", 256'(in_ready), 256'(1'b0));
        chk("rst_ov", 256'(out_valid), 256'(1'b0));
        chk("rst_busy", 256'(busy), 256'(1'b0));
        chk("rst_done", 256'(done), 256'(1'b0));
        chk("rst_wcnt", 256'(win_cnt), 256'(0));
        chk("rst_od", 256'(|out_data), 256'(1'b0));
        chk("rst_bpi", 256'(bin_pixel_in), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_busy", 256'(busy), 256'(1'b0));

        // single window, directed pixel values
        out_ready = 1'b1;
        do_start(1);
        foreach (pix[i]) send_px(pix[i]);
        @(negedge clk);
        chk("sw_lat0", 256'(out_valid), 256'(1'b0));
        @(negedge clk);
        chk("sw_lat1", 256'(out_valid), 256'(1'b1));
        chk("sw_e0_ones", 256'($countones(out_data[0 +: CH])), 256'(128));
        chk("sw_e1_ones", 256'($countones(out_data[CH +: CH])), 256'(255));
        chk("sw_e2", out_data[2*CH +: CH], 256'(0));
        chk("sw_e3_ones", 256'($countones(out_data[3*CH +: CH])), 256'(129));
        chk("sw_e4_ones", 256'($countones(out_data[4*CH +: CH])), 256'(127));
        @(negedge clk);
        chk("sw_ov_1cyc", 256'(out_valid), 256'(1'b0));
        chk("sw_done_early", 256'(done), 256'(1'b0));
        chk("sw_wcnt", 256'(win_cnt), 256'(1));
        @(negedge clk);
        chk("sw_done", 256'(done), 256'(1'b1));
        chk("sw_busy_drop", 256'(busy), 256'(1'b0));
        @(negedge clk);
        chk("sw_done_1cyc", 256'(done), 256'(1'b0));
        check_wins("sw", 1);
        @(posedge clk);
        #1;

        // empty frame
        do_start(0);
        @(negedge clk);
        chk("z_done", 256'(done), 256'(1'b1));
        chk("z_busy", 256'(busy), 256'(1'b0));
        chk("z_inrdy", 256'(in_ready), 256'(1'b0));
        @(negedge clk);
        chk("z_done_1cyc", 256'(done), 256'(1'b0));
        chk("z_busy2", 256'(busy), 256'(1'b0));
        @(posedge clk);
        #1;

        // backpressure
        out_ready = 1'b0;
        do_start(3);
        @(negedge clk);
        chk("bp_busy", 256'(busy), 256'(1'b1));
        chk("bp_inrdy", 256'(in_ready), 256'(1'b1));
        @(posedge clk);
        #1;
        for (int i = 0; i < 2*K; i++) send_px(8'($urandom));
        saw = 1'b0;
        repeat (30) begin
            @(negedge clk);
            saw |= in_ready;
        end
        chk("bp_hold_inrdy", 256'(saw), 256'(1'b0));
        chk("bp_hold_ov", 256'(out_valid), 256'(1'b1));
        chk("bp_hold_wcnt", 256'(win_cnt), 256'(0));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < K; i++) send_px(8'($urandom));
        wait_done(500);
        chk("bp_wcnt", 256'(win_cnt), 256'(3));
        check_wins("bp", 3);

        // abort mid window 2, then fresh frame
        do_start(3);
        for (int i = 0; i < K + 5; i++) send_px(8'($urandom));
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        dc = done_cnt;
        @(negedge clk);
        chk("ab_busy", 256'(busy), 256'(1'b0));
        chk("ab_inrdy", 256'(in_ready), 256'(1'b0));
        chk("ab_wcnt", 256'(win_cnt), 256'(1));
        repeat (3) @(negedge clk);
        chk("ab_nodone", 256'(done_cnt - dc), 256'(0));
        while (sent_q.size() > K) void'(sent_q.pop_back());
        check_wins("ab_w1", 1);
        @(posedge clk);
        #1;
        do_start(1);
        send_px(8'h5A);
        @(negedge clk);
        chk("ab_idx0", 256'(bin_pixel_in[BW-1:0]), 256'(8'h5A));
        @(posedge clk);
        #1;
        for (int i = 1; i < K; i++) send_px(8'($urandom));
        wait_done(100);
        check_wins("ab_w2", 1);

        // asynchronous reset with a window in the output stage
        out_ready = 1'b0;
        do_start(2);
        for (int i = 0; i < K; i++) send_px(8'($urandom));
        @(negedge clk);
        @(negedge clk);
        chk("ar_pre_ov", 256'(out_valid), 256'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_ov", 256'(out_valid), 256'(1'b0));
        chk("ar_inrdy", 256'(in_ready), 256'(1'b0));
        chk("ar_busy", 256'(busy), 256'(1'b0));
        chk("ar_od", 256'(|out_data), 256'(1'b0));
        chk("ar_bpi", 256'(|bin_pixel_in), 256'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_idle", 256'(busy), 256'(1'b0));
        got_q.delete();
        sent_q.delete();
        @(posedge clk);
        #1;

        // random frames with stray starts and random flow control
        for (int r = 0; r < 3; r++) begin
            nw = $urandom_range(3, 6);
            fin = 1'b0;
            do_start(nw);
            fork
                begin
                    for (int i = 0; i < nw*K; i++) begin
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge clk);
                            #1;
                        end
                        start = ($urandom_range(0, 3) == 0);
                        num_windows = CW'($urandom);
                        send_px(8'($urandom));
                        start = 1'b0;
                    end
                    wait_done(3000);
                    fin = 1'b1;
                end
                begin
                    while (!fin) begin
                        @(posedge clk);
                        #1;
                        out_ready = ($urandom_range(0, 1) == 1);
                    end
                    out_ready = 1'b1;
                end
            join
            chk("rnd_wcnt", 256'(win_cnt), 256'(nw));
            chk("rnd_idle", 256'(busy), 256'(1'b0));
            check_wins("rnd", nw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
